mlp_argmax: RTL
===============

// Module: mlp_argmax
// PURPOSE
// - Final classification stage of the MLP: consumes the N_CLASSES FP32 scores of the last layer
//   (END_LAYER=1, no ReLU) and reports the index and value of the largest score.
// - Scans one score per cycle, so area is independent of N_CLASSES.
// - Starts on the last layer's layer_end, wired to prev_layer_end; same chaining convention as a layer.
// PARAMETERS
// - N_CLASSES  default 10  number of scores / classes; legal range >= 1
// - IDX_W      localparam  ($N_CLASSES>1) ? $clog2(N_CLASSES) : 1
// PORTS
// - CLK             in   1        single clock; all state updates on posedge
// - reset           in   1        asynchronous, active-high; clears all state immediately
// - scores          in   32 x N   [0:N_CLASSES-1] IEEE 754 binary32; held stable by upstream while prev_layer_end=1
// - prev_layer_end  in   1        level; 1 = scores valid, start/keep running; 0 = idle/abort
// - class_idx       out  IDX_W    index of max score
// - max_value       out  32       max score, FP32 bit pattern
// - nan_seen        out  1        1 if any scanned score was NaN in the current pass
// - argmax_end      out  1        1 = class_idx/max_value/nan_seen final and valid
// BEHAVIOUR
// - Reset (async): state=IDLE, ptr=0, class_idx=0, max_value=0, nan_seen=0, argmax_end=0.
// - Ordering key: canonicalise -0 (32'h80000000) to +0; key = sign ? ~x : x ^ 32'h80000000; compare keys unsigned.
// - NaN (exp=8'hFF, mant!=0): ranks below every non-NaN, including -inf.
//   - Incumbent NaN is replaced by any non-NaN.
//   - NaN never replaces anything.
//   - Sets nan_seen.
// - Update only on strictly greater; ties keep the lowest index.
// - max_value is the original, uncanonicalised bits of the winning score.
// - FSM: IDLE, SCAN, DONE.
//   - IDLE & prev_layer_end=1 (edge k):
//     - best <= scores[0], class_idx <= 0, nan_seen <= isNaN(scores[0]), ptr <= 1.
//     - Go to SCAN; if N_CLASSES==1, go directly to DONE with argmax_end <= 1.
//   - SCAN & prev_layer_end=1:
//     - Compare scores[ptr] with best and update; ptr <= ptr+1.
//     - When ptr==N_CLASSES-1: state <= DONE, argmax_end <= 1, with the final update on the same edge.
//   - DONE & prev_layer_end=1: hold all outputs; argmax_end stays 1; no rescan.
//   - Any state & prev_layer_end=0 at an edge: state <= IDLE, argmax_end <= 0, ptr <= 0.
//     - class_idx/max_value/nan_seen hold their last values and are not valid.
// - Latency: start edge k; argmax_end rises on edge k+N_CLASSES-1; for N_CLASSES==1, on edge k.
// - Abort mid-SCAN (prev_layer_end drops): IDLE next edge; a new pass restarts from index 0.
// - Reset mid-SCAN: immediate return to reset values, asynchronous to CLK.
// - Re-trigger needs prev_layer_end low for >=1 edge, then high again; upstream reset provides this.
// - ptr never exceeds N_CLASSES-1; no wrap.
// - No arithmetic FPU is used; the compare is integer only, combinational on the scores[ptr] mux plus best.
// TESTING
// - N=10; scores={1.0,2.0,0.5,-1.0,...(rest -2.0)}, i.e. 3F800000,40000000,3F000000,BF800000,C0000000...
//   -> argmax_end rises 9 cycles after start; class_idx=1, max_value=40000000, nan_seen=0.
// - All-negative: scores[i]=-(i+1).0 (BF800000,C0000000,...)
//   -> class_idx=0, max_value=BF800000.
// - Ties and zeros:
//   - scores[2]=80000000(-0), scores[5]=00000000(+0), others negative -> class_idx=2 (equal, lowest wins).
//   - scores[3]=scores[7]=3F800000 -> class_idx=3.
// - NaN handling:
//   - scores[0]=7FC00000, scores[4]=FF800000(-inf), others NaN -> class_idx=4, max_value=FF800000, nan_seen=1.
//   - All NaN -> class_idx=0, nan_seen=1.
// - Abort/reset:
//   - Drop prev_layer_end after 4 SCAN cycles -> argmax_end stays 0, IDLE.
//   - Re-raise -> full pass, correct result 9 cycles later.
//   - Assert reset asynchronously mid-SCAN -> all outputs 0 before the next CLK edge.
// - N_CLASSES=1: scores[0]=7F800000 -> argmax_end=1 on the start edge, class_idx=0, max_value=7F800000.

Source files
------------

// File: rtl/mlp_argmax.sv
// Sequential argmax over the FP32 scores of the final MLP layer: one score per cycle,
// integer-only ordering, NaN ranked below everything, ties resolved to the lowest index.
module mlp_argmax #(
   parameter int unsigned N_CLASSES = 10
) (
   input  logic                                                CLK,
   input  logic                                                reset,
   input  logic [31:0]                                         scores [0:N_CLASSES-1],
   input  logic                                                prev_layer_end,
   output logic [((N_CLASSES > 1) ? $clog2(N_CLASSES) : 1)-1:0] class_idx,
   output logic [31:0]                                         max_value,
   output logic                                                nan_seen,
   output logic                                                argmax_end
);

   localparam int unsigned IDX_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [31:0]        best_q, best_d;
   logic               nan_q, nan_d;
   logic               end_q, end_d;

   logic [31:0]        cand;
   logic               cand_nan;
   logic               best_nan;
   logic               cand_wins;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Maps FP32 bits to an unsigned key whose integer order matches numeric order.
   function automatic logic [31:0] order_key(input logic [31:0] x);
      logic [31:0] c;
      c = (x == 32'h8000_0000) ? 32'h0000_0000 : x;
      return c[31] ? ~c : (c ^ 32'h8000_0000);
   endfunction

   assign cand     = scores[ptr_q];
   assign cand_nan = is_nan(cand);
   assign best_nan = is_nan(best_q);
   assign cand_wins = !cand_nan && (best_nan || (order_key(cand) > order_key(best_q)));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      best_d  = best_q;
      nan_d   = nan_q;
      end_d   = end_q;
      if (!prev_layer_end) begin
         state_d = StIdle;
         end_d   = 1'b0;
         ptr_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               best_d = scores[0];
               idx_d  = '0;
               nan_d  = is_nan(scores[0]);
               if (N_CLASSES == 1) begin
                  state_d = StDone;
                  end_d   = 1'b1;
                  ptr_d   = '0;
               end else begin
                  state_d = StScan;
                  ptr_d   = IDX_W'(1);
               end
            end
            StScan: begin
               if (cand_wins) begin
                  best_d = cand;
                  idx_d  = ptr_q;
               end
               nan_d = nan_q | cand_nan;
               if (ptr_q == LAST) begin
                  state_d = StDone;
                  end_d   = 1'b1;
               end else begin
                  ptr_d = ptr_q + IDX_W'(1);
               end
            end
            StDone: begin
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         idx_q   <= '0;
         best_q  <= 32'h0;
         nan_q   <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         best_q  <= best_d;
         nan_q   <= nan_d;
         end_q   <= end_d;
      end
   end

   assign class_idx  = idx_q;
   assign max_value  = best_q;
   assign nan_seen   = nan_q;
   assign argmax_end = end_q;

endmodule
